// File: rtl/apb_arb_pkg.sv
// Shared types for the two-master APB arbiter: FSM states and grant encoding.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } arb_state_t;

    localparam logic GNT_M0 = 1'b0;
    localparam logic GNT_M1 = 1'b1;

    function automatic logic in_transfer(arb_state_t s);
        return (s == SETUP) || (s == ACCESS);
    endfunction

endpackage

// File: rtl/apb_master_arb_if.sv
// APB bundle used on both sides of the arbiter. Upstream masters connect through
// the slave modport, and the downstream fabric connects through the master modport.
interface apb_master_arb_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pdata;
    logic                  pwrite;
    logic [3:0]            pstb;
    logic                  psel;
    logic                  penable;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  perr;

    modport master (
        output paddr, pdata, pwrite, pstb, psel, penable,
        input  prdata, pready, perr
    );

    // Upstream penable is deliberately absent: psel alone is the request.
    modport slave (
        input  paddr, pdata, pwrite, pstb, psel,
        output prdata, pready, perr
    );
endinterface

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker: on a tie, the master not granted last time wins.
module rr_arb2
    import apb_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       valid_o,
    output logic       winner_o
);

    assign valid_o  = |req_i;
    assign winner_o = (&req_i) ? ((last_i == GNT_M0) ? GNT_M1 : GNT_M0)
                               : (req_i[1] ? GNT_M1 : GNT_M0);

endmodule

// File: rtl/apb_master_arb.sv
// Two-master APB arbiter driving one downstream APB port with a clean SETUP/ACCESS.
// Optional ACCESS watchdog enabled by defining APB_ARB_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | no transfer; arbitrate among requesting masters
// SETUP  | psel=1, penable=0 for the granted master
// ACCESS | psel=1, penable=1; wait for downstream pready (or watchdog)
module apb_master_arb
    import apb_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
`ifdef APB_ARB_TIMEOUT_EN
    ,parameter int TIMEOUT_CYCLES = 255
`endif
)(
    input  logic             clk,
    input  logic             APB_PRESETn,
    apb_master_arb_if.slave  m0_if,
    apb_master_arb_if.slave  m1_if,
    apb_master_arb_if.master apb_if
);

    arb_state_t state_q;
    logic       grant_q;
    logic       last_q;
    logic       psel_q;
    logic       penable_q;

    logic       arb_valid;
    logic       arb_winner;
    logic       timeout_hit;
    logic       done;
    logic       err_rsp;

    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_write;
    logic [3:0]            sel_stb;

    rr_arb2 u_rr_arb2 (
        .req_i    ({m1_if.psel, m0_if.psel}),
        .last_i   (last_q),
        .valid_o  (arb_valid),
        .winner_o (arb_winner)
    );

`ifdef APB_ARB_TIMEOUT_EN
    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    // Down-counter loaded in SETUP; terminal count on the last allowed ACCESS cycle.
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == SETUP) begin
            cnt_d = CNT_LOAD;
        end else if ((state_q == ACCESS) && !apb_if.pready && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge APB_PRESETn) begin
        if (!APB_PRESETn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_hit = (state_q == ACCESS) && !apb_if.pready && (cnt_q == '0);
`else
    assign timeout_hit = 1'b0;
`endif

    assign done    = (state_q == ACCESS) && (apb_if.pready || timeout_hit);
    assign err_rsp = apb_if.pready ? apb_if.perr : 1'b1;

    always_ff @(posedge clk or negedge APB_PRESETn) begin
        if (!APB_PRESETn) begin
            state_q   <= IDLE;
            grant_q   <= GNT_M0;
            last_q    <= GNT_M1;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arb_valid) begin
                        grant_q <= arb_winner;
                        last_q  <= arb_winner;
                        psel_q  <= 1'b1;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    if (done) begin
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        sel_addr  = '0;
        sel_data  = '0;
        sel_write = 1'b0;
        sel_stb   = 4'b0000;
        if (in_transfer(state_q)) begin
            if (grant_q == GNT_M1) begin
                sel_addr  = m1_if.paddr;
                sel_data  = m1_if.pdata;
                sel_write = m1_if.pwrite;
                sel_stb   = m1_if.pstb;
            end else begin
                sel_addr  = m0_if.paddr;
                sel_data  = m0_if.pdata;
                sel_write = m0_if.pwrite;
                sel_stb   = m0_if.pstb;
            end
        end
    end

    assign apb_if.paddr   = sel_addr;
    assign apb_if.pdata   = sel_data;
    assign apb_if.pwrite  = sel_write;
    assign apb_if.pstb    = sel_stb;
    assign apb_if.psel    = psel_q;
    assign apb_if.penable = penable_q;

    // Read data is broadcast; only the granted master ever sees pready/perr.
    assign m0_if.prdata = apb_if.prdata;
    assign m1_if.prdata = apb_if.prdata;
    assign m0_if.pready = done && (grant_q == GNT_M0);
    assign m1_if.pready = done && (grant_q == GNT_M1);
    assign m0_if.perr   = done && (grant_q == GNT_M0) && err_rsp;
    assign m1_if.perr   = done && (grant_q == GNT_M1) && err_rsp;

endmodule

// File: doc/apb_master_arb.md
Name: apb_master_arb

Overview:
Two-master APB arbiter placed between the bus masters and the APB decoder/fabric. Master 0 is the cpu and master 1 is a secondary master such as a DMA or debug port.
- Grants the single downstream APB master port round-robin.
- Regenerates a clean SETUP/ACCESS sequence for the winner.
- Stalls the loser by holding its pready low.
Downstream pins connect directly to the APB fabric's master-side ports.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, data width of all ports
TIMEOUT_CYCLES, 255, max ACCESS cycles before forced error (optional feature only)

Ports:
clk  input  1  system clock, all logic on rising edge
APB_PRESETn  input  1  asynchronous active-low reset
mN_paddr (N=0,1)  input  ADDR_WIDTH  master N address
mN_pdata  input  DATA_WIDTH  master N write data
mN_psel  input  1  master N request; held until its pready
mN_pwrite  input  1  master N write enable
mN_pstb  input  4  master N byte strobes
mN_prdata  output  DATA_WIDTH  read data returned to master N
mN_pready  output  1  transfer complete for master N
mN_perr  output  1  error response for master N
APB_paddr  output  ADDR_WIDTH  downstream address
APB_pdata  output  DATA_WIDTH  downstream write data
APB_pwrite  output  1  downstream write
APB_pstb  output  4  downstream strobes
APB_psel  output  1  downstream select
APB_penable  output  1  downstream enable
APB_prdata  input  DATA_WIDTH  downstream read data
APB_pready  input  1  downstream ready
APB_perr  input  1  downstream error

Behaviour:
- Clock and reset: one clock (clk). Reset APB_PRESETn is asynchronous, active-low.
- Reset state:
  - state=IDLE, grant=none, last_grant=1 (so m0 wins the first tie).
  - All outputs are 0.
  - Reset asserted mid-transfer drops APB_psel/APB_penable and mN_pready immediately.
- Master penable is ignored. psel alone is the request.
- State machine:
  - IDLE: if any mN_psel=1, pick a winner. Single requester wins. If both request, the master not equal to last_grant wins. Register grant and last_grant, go to SETUP.
  - SETUP: APB_psel=1, APB_penable=0. Go to ACCESS.
  - ACCESS: APB_psel=1, APB_penable=1. When APB_pready=1, pulse the granted mN_pready=1 and mN_perr=APB_perr this cycle, then go to IDLE.
- Downstream mux:
  - APB_paddr/pdata/pwrite/pstb come combinationally from the granted master in SETUP/ACCESS.
  - All four are forced to 0 in IDLE.
- Read data: mN_prdata=APB_prdata, broadcast to both masters. Only the granted master's pready/perr may assert. The non-granted master's pready and perr stay 0.
- Latency: a request in IDLE at cycle t completes no earlier than cycle t+2 (SETUP t+1, ACCESS t+2). There is one mandatory IDLE cycle between transfers.
- A master deasserting psel while in SETUP/ACCESS is a protocol violation. The transfer completes regardless.
- Simultaneous events:
  - A request arriving during another master's transfer waits; that master sees pready=0.
  - After completion, IDLE re-arbitrates, so back-to-back requesters alternate.
- Strobes (pstb) and width pass through unchanged. No arithmetic on data.

Optional Feature:
Macro APB_ARB_TIMEOUT_EN.
- With the macro:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on SETUP and increments each ACCESS cycle that APB_pready=0.
  - When it reaches TIMEOUT_CYCLES-1 with APB_pready=0, the arbiter drives the granted mN_pready=1, mN_perr=1 and goes to IDLE. APB_psel drops next cycle.
  - APB_pready=1 on the same cycle takes priority: a normal completion.
- Without the macro: no counter. ACCESS waits indefinitely for APB_pready.

Decomposition:
- Package apb_arb_pkg holds:
  - state enum {IDLE, SETUP, ACCESS}
  - grant encoding constants GNT_M0=0, GNT_M1=1
- Sub-module rr_arb2 holds the combinational 2-way round-robin picker: inputs req[1:0] and last; outputs valid and winner.

Test Plan:
- m0 read at 0x100, slave pready on first ACCESS cycle with prdata=0xDEADBEEF -> m0_pready=1 at t+2, m0_prdata=0xDEADBEEF; m1_pready stays 0.
- m0 and m1 both request at the same cycle after reset -> m0 served first, m1 served next. Grant order repeating under continuous requests is m0,m1,m0,m1.
- m1 write 0x12345678 with pstb=4'b0011 while m0 is mid-transfer with 3 slave wait states -> m1 is stalled, then the downstream shows paddr/pdata/pstb of m1 with APB_pwrite=1.
- Slave returns APB_perr=1 with pready -> the granted mN_perr=1 for one cycle; the other master's perr stays 0.
- APB_PRESETn pulsed low during ACCESS -> APB_psel/APB_penable/mN_pready are 0 within the same cycle; after release, the next both-requesting arbitration grants m0.
- With APB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, slave never readies -> the master gets pready=1, perr=1 on the 8th ACCESS cycle, then IDLE.
